// File: rtl/player_input_ctrl_pkg.sv
// Shared player-input constants: button bit positions, default button count and a clog2 helper.
package player_input_ctrl_pkg;

    // Bit position of each button inside one player's slice
    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_JUMP  = 2;
    localparam int unsigned BTN_ATK   = 3;
    localparam int unsigned BTN_BLOCK = 4;

    localparam int unsigned DEFAULT_NUM_BUTTONS = 5;

    // Bits needed to index 'value' distinct items; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((v >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/player_input_ctrl_debounce.sv
// One button: polarity fix, two-flop synchroniser and a stable-count debouncer.
module input_debounce
    import player_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic stable_o
);

    localparam int unsigned CNT_W = (clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1
                                                                    : clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             level_c;
    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign level_c  = pin_i ^ ACTIVE_LOW;
    assign stable_o = stable_q;

    // Accept a change only after the synchronised level has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (DEBOUNCE_CYCLES == 0) begin
            stable_d = sync_q;
        end else if (sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, counter and stable state; reset means "released" and drops any partial count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= level_c;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/player_input_ctrl.sv
// Player input front end: per-button debounce, frame latching, edge detection and input history.
module player_input_ctrl
    import player_input_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = 2,
    parameter int unsigned NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HIST_DEPTH      = 8,
    parameter bit          ACTIVE_LOW      = 1'b1,
    localparam int unsigned NB     = NUM_PLAYERS * NUM_BUTTONS,
    localparam int unsigned PSEL_W = (clog2(NUM_PLAYERS) < 1) ? 1 : clog2(NUM_PLAYERS),
    localparam int unsigned IDX_W  = clog2(HIST_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NB-1:0]          btn_raw,
    input  logic                   frame_tick,
    input  logic [PSEL_W-1:0]      hist_player,
    input  logic [IDX_W-1:0]       hist_index,
    output logic [NB-1:0]          btn_frame,
    output logic [NB-1:0]          btn_pressed,
    output logic [NB-1:0]          btn_released,
    output logic                   frame_valid,
    output logic [NUM_BUTTONS-1:0] hist_data
);

    localparam int unsigned CNT_HW = clog2(HIST_DEPTH + 1);

    logic [NB-1:0]          stable;
    logic [NB-1:0]          btn_frame_q;
    logic [NB-1:0]          btn_frame_d;
    logic [NB-1:0]          btn_pressed_q;
    logic [NB-1:0]          btn_pressed_d;
    logic [NB-1:0]          btn_released_q;
    logic [NB-1:0]          btn_released_d;
    logic                   frame_valid_q;
    logic                   frame_valid_d;
    logic [IDX_W-1:0]       wptr_q;
    logic [IDX_W-1:0]       wptr_d;
    logic [CNT_HW-1:0]      hist_count_q;
    logic [CNT_HW-1:0]      hist_count_d;
    logic [NB-1:0]          hist_mem_q [HIST_DEPTH];
    logic [IDX_W-1:0]       rd_addr;
    logic [NB-1:0]          rd_row;
    logic [NUM_BUTTONS-1:0] hist_data_q;
    logic [NUM_BUTTONS-1:0] hist_data_d;

    // One synchroniser/debouncer per button pin
    for (genvar g = 0; g < NB; g++) begin : g_btn
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .pin_i   (btn_raw[g]),
            .stable_o(stable[g])
        );
    end

    // Frame latch, edge detect and history pointers; everything holds between ticks
    always_comb begin
        btn_frame_d    = btn_frame_q;
        btn_pressed_d  = btn_pressed_q;
        btn_released_d = btn_released_q;
        frame_valid_d  = frame_tick;
        wptr_d         = wptr_q;
        hist_count_d   = hist_count_q;
        if (frame_tick) begin
            btn_frame_d    = stable;
            btn_pressed_d  = stable & ~btn_frame_q;
            btn_released_d = ~stable & btn_frame_q;
            wptr_d         = wptr_q + IDX_W'(1);
            if (hist_count_q != CNT_HW'(HIST_DEPTH)) begin
                hist_count_d = hist_count_q + CNT_HW'(1);
            end
        end
    end

    // History read: newest entry sits just behind wptr; unwritten ages and absent players read 0
    always_comb begin
        rd_addr     = wptr_q - IDX_W'(1) - hist_index;
        rd_row      = hist_mem_q[rd_addr];
        hist_data_d = '0;
        if (CNT_HW'(hist_index) < hist_count_q) begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                if (hist_player == PSEL_W'(p)) begin
                    hist_data_d = rd_row[p*NUM_BUTTONS +: NUM_BUTTONS];
                end
            end
        end
    end

    // Output and pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_frame_q    <= '0;
            btn_pressed_q  <= '0;
            btn_released_q <= '0;
            frame_valid_q  <= 1'b0;
            wptr_q         <= '0;
            hist_count_q   <= '0;
            hist_data_q    <= '0;
        end else begin
            btn_frame_q    <= btn_frame_d;
            btn_pressed_q  <= btn_pressed_d;
            btn_released_q <= btn_released_d;
            frame_valid_q  <= frame_valid_d;
            wptr_q         <= wptr_d;
            hist_count_q   <= hist_count_d;
            hist_data_q    <= hist_data_d;
        end
    end

    // History storage; stale rows after reset are hidden by the hist_count guard
    always_ff @(posedge clk) begin
        if (frame_tick) begin
            hist_mem_q[wptr_q] <= stable;
        end
    end

    assign btn_frame    = btn_frame_q;
    assign btn_pressed  = btn_pressed_q;
    assign btn_released = btn_released_q;
    assign frame_valid  = frame_valid_q;
    assign hist_data    = hist_data_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with 3 players, 5 buttons, 4-cycle debounce, 8-deep history.
module tb_player_input_ctrl;
    import player_input_ctrl_pkg::*;

    localparam int unsigned P  = 3;
    localparam int unsigned B  = 5;
    localparam int unsigned D  = 4;
    localparam int unsigned H  = 8;
    localparam int unsigned NB = P * B;
    localparam logic [NB-1:0] IDLE = '1;
    localparam logic [NB-1:0] M_ATK1 = NB'(1) << (1 * B + BTN_ATK);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_raw = IDLE;
    logic          frame_tick = 1'b0;
    logic [1:0]    hist_player = '0;
    logic [2:0]    hist_index = '0;
    logic [NB-1:0] btn_frame;
    logic [NB-1:0] btn_pressed;
    logic [NB-1:0] btn_released;
    logic          frame_valid;
    logic [B-1:0]  hist_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    player_input_ctrl #(
        .NUM_PLAYERS    (P),
        .NUM_BUTTONS    (B),
        .DEBOUNCE_CYCLES(D),
        .HIST_DEPTH     (H),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .frame_tick  (frame_tick),
        .hist_player (hist_player),
        .hist_index  (hist_index),
        .btn_frame   (btn_frame),
        .btn_pressed (btn_pressed),
        .btn_released(btn_released),
        .frame_valid (frame_valid),
        .hist_data   (hist_data)
    );

    // Advance n clock edges, landing 1 time unit after the last rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick;
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    // Distinct 5-bit pattern for player p in frame k
    function automatic logic [B-1:0] pat(input int p, input int k);
        return 5'((k * 7 + p * 11 + 1) % 32);
    endfunction

    task automatic test_reset;
        btn_raw = IDLE;
        frame_tick = 1'b0;
        reset = 1'b1;
        cyc(2);
        checks++;
        if ({btn_frame, btn_pressed, btn_released, frame_valid, hist_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h/%h/%b/%h required all zero",
                     btn_frame, btn_pressed, btn_released, frame_valid, hist_data);
        end
        reset = 1'b0;
        cyc(3);
        for (int t = 0; t < 3; t++) begin
            do_tick;
            checks++;
            if (frame_valid !== 1'b1) begin
                errors++;
                $display("FAIL idle_valid tick %0d: got %b required 1", t, frame_valid);
            end
            checks++;
            if ({btn_frame, btn_pressed, btn_released} !== '0) begin
                errors++;
                $display("FAIL idle_frame tick %0d: got %h/%h/%h required 0", t,
                         btn_frame, btn_pressed, btn_released);
            end
        end
        cyc(1);
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid_drop: got %b required 0", frame_valid);
        end
        for (int p = 0; p < int'(P); p++) begin
            for (int i = 0; i < int'(H); i++) begin
                hist_player = 2'(p);
                hist_index = 3'(i);
                cyc(1);
                checks++;
                if (hist_data !== '0) begin
                    errors++;
                    $display("FAIL idle_hist p%0d i%0d: got %h required 0", p, i, hist_data);
                end
            end
        end
    endtask

    task automatic test_debounce;
        // 3-cycle glitch must be filtered
        btn_raw = IDLE & ~M_ATK1;
        cyc(3);
        btn_raw = IDLE;
        cyc(10);
        do_tick;
        checks++;
        if ({btn_frame, btn_pressed} !== '0) begin
            errors++;
            $display("FAIL glitch: got frame %h pressed %h required 0", btn_frame, btn_pressed);
        end
        // 10-cycle press: stable rises on edge 7 after the pin change
        btn_raw = IDLE & ~M_ATK1;
        cyc(6);
        do_tick;
        checks++;
        if ({btn_frame, btn_pressed} !== '0) begin
            errors++;
            $display("FAIL press_edge7: got frame %h pressed %h required 0", btn_frame, btn_pressed);
        end
        do_tick;
        checks++;
        if (btn_pressed !== M_ATK1 || btn_frame !== M_ATK1 || btn_released !== '0) begin
            errors++;
            $display("FAIL press_edge8: got f %h p %h r %h required f %h p %h r 0",
                     btn_frame, btn_pressed, btn_released, M_ATK1, M_ATK1);
        end
        checks++;
        if (frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL press_valid: got %b required 1", frame_valid);
        end
        do_tick;
        checks++;
        if (btn_pressed !== '0 || btn_frame !== M_ATK1) begin
            errors++;
            $display("FAIL press_hold: got f %h p %h required f %h p 0",
                     btn_frame, btn_pressed, M_ATK1);
        end
        cyc(1);
        btn_raw = IDLE;
        cyc(8);
        do_tick;
        checks++;
        if (btn_released !== M_ATK1 || btn_frame !== '0 || btn_pressed !== '0) begin
            errors++;
            $display("FAIL release: got f %h p %h r %h required f 0 p 0 r %h",
                     btn_frame, btn_pressed, btn_released, M_ATK1);
        end
    endtask

    task automatic test_release_same_cycle;
        btn_raw = IDLE & ~NB'(1);
        cyc(10);
        do_tick;
        checks++;
        if (btn_frame !== NB'(1) || btn_pressed !== NB'(1)) begin
            errors++;
            $display("FAIL rsc_press: got f %h p %h required 0001", btn_frame, btn_pressed);
        end
        btn_raw = IDLE;
        cyc(6);
        do_tick;
        checks++;
        if (btn_frame !== NB'(1) || btn_released !== '0 || btn_pressed !== '0) begin
            errors++;
            $display("FAIL rsc_same: got f %h p %h r %h required f 0001 p 0 r 0",
                     btn_frame, btn_pressed, btn_released);
        end
        do_tick;
        checks++;
        if (btn_frame !== '0 || btn_released !== NB'(1)) begin
            errors++;
            $display("FAIL rsc_next: got f %h r %h required f 0 r 0001", btn_frame, btn_released);
        end
    endtask

    task automatic test_history_wrap;
        logic [NB-1:0] cur;
        logic [NB-1:0] prev;
        cur = '0;
        prev = '0;
        for (int k = 1; k <= 10; k++) begin
            prev = cur;
            cur = {pat(2, k), pat(1, k), pat(0, k)};
            btn_raw = ~cur;
            cyc(8);
            do_tick;
        end
        checks++;
        if (btn_frame !== cur || btn_pressed !== (cur & ~prev) || btn_released !== (~cur & prev)) begin
            errors++;
            $display("FAIL wrap_frame: got f %h p %h r %h required f %h p %h r %h",
                     btn_frame, btn_pressed, btn_released, cur, cur & ~prev, ~cur & prev);
        end
        for (int i = 0; i < int'(H); i++) begin
            hist_player = 2'd2;
            hist_index = 3'(i);
            cyc(1);
            checks++;
            if (hist_data !== pat(2, 10 - i)) begin
                errors++;
                $display("FAIL wrap_p2 i%0d: got %h required %h", i, hist_data, pat(2, 10 - i));
            end
        end
        hist_player = 2'd0;
        hist_index = 3'd0;
        cyc(1);
        checks++;
        if (hist_data !== pat(0, 10)) begin
            errors++;
            $display("FAIL wrap_p0 i0: got %h required %h", hist_data, pat(0, 10));
        end
        hist_player = 2'd1;
        hist_index = 3'd7;
        cyc(1);
        checks++;
        if (hist_data !== pat(1, 3)) begin
            errors++;
            $display("FAIL wrap_p1 i7: got %h required %h", hist_data, pat(1, 3));
        end
        hist_player = 2'd3;
        hist_index = 3'd0;
        cyc(1);
        checks++;
        if (hist_data !== '0) begin
            errors++;
            $display("FAIL wrap_p3: got %h required 0", hist_data);
        end
        // Read of index 0 in the same cycle as a write sees the previous frame
        btn_raw = ~{pat(2, 11), pat(1, 11), pat(0, 11)};
        cyc(8);
        hist_player = 2'd2;
        hist_index = 3'd0;
        do_tick;
        checks++;
        if (hist_data !== pat(2, 10)) begin
            errors++;
            $display("FAIL rw_same: got %h required %h", hist_data, pat(2, 10));
        end
        cyc(1);
        checks++;
        if (hist_data !== pat(2, 11)) begin
            errors++;
            $display("FAIL rw_after: got %h required %h", hist_data, pat(2, 11));
        end
    endtask

    task automatic test_hist_guard;
        logic [2:0] idx [4];
        logic [B-1:0] exp [4];
        idx = '{3'd5, 3'd2, 3'd1, 3'd0};
        exp = '{5'h00, 5'h00, 5'h13, 5'h13};
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        btn_raw = ~NB'(5'h13);
        cyc(8);
        do_tick;
        do_tick;
        for (int j = 0; j < 4; j++) begin
            hist_player = 2'd0;
            hist_index = idx[j];
            cyc(1);
            checks++;
            if (hist_data !== exp[j]) begin
                errors++;
                $display("FAIL guard i%0d: got %h required %h", idx[j], hist_data, exp[j]);
            end
        end
    endtask

    task automatic test_reset_mid_debounce;
        btn_raw = IDLE & ~M_ATK1;
        cyc(5);
        #2;
        checks++;
        if (btn_frame !== NB'(5'h13)) begin
            errors++;
            $display("FAIL mid_pre: got %h required %h", btn_frame, NB'(5'h13));
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({btn_frame, btn_pressed, btn_released, frame_valid, hist_data} !== '0) begin
            errors++;
            $display("FAIL mid_async: got %h/%h/%h/%b/%h required all zero",
                     btn_frame, btn_pressed, btn_released, frame_valid, hist_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_tick;
        checks++;
        if (btn_pressed !== '0 || btn_frame !== '0) begin
            errors++;
            $display("FAIL mid_first: got f %h p %h required 0", btn_frame, btn_pressed);
        end
        cyc(4);
        do_tick;
        checks++;
        if (btn_pressed !== '0) begin
            errors++;
            $display("FAIL mid_edge6: got %h required 0", btn_pressed);
        end
        do_tick;
        checks++;
        if (btn_pressed !== '0) begin
            errors++;
            $display("FAIL mid_edge7: got %h required 0", btn_pressed);
        end
        do_tick;
        checks++;
        if (btn_pressed !== M_ATK1 || btn_frame !== M_ATK1) begin
            errors++;
            $display("FAIL mid_edge8: got f %h p %h required %h", btn_frame, btn_pressed, M_ATK1);
        end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_release_same_cycle;
        test_history_wrap;
        test_hist_guard;
        test_reset_mid_debounce;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
